tap_scan_controller: RTL and testbench

- IEEE 1149.1-style TAP controller that sequences the 8-bit boundary-scan register (BSR) chain.
- Decodes TMS into the 16-state TAP FSM and generates the BSR strobes shiftDR, clockDR, updateDR and mode.
- Holds a 3-bit instruction register (IR) that selects between the BSR and a 1-bit bypass register.
- Muxes the selected chain onto TDO. Sits between the chip-level JTAG pins and the BSR instance.

---
 rtl/tap_pkg.sv | 33 +++
 rtl/tap_scan_controller_if.sv | 31 +++
 rtl/tap_instruction_register.sv | 56 +++++
 rtl/tap_scan_controller.sv | 112 +++++++++++
 tb/tb_tap_scan_controller.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tap_pkg.sv
// Shared definitions for the TAP scan controller: the 1149.1 state
// encodings, the instruction opcodes and the default IR width.
// Ports: none (package).
package tap_pkg;

  localparam int IR_SIZE = 3;
  localparam int STATE_W = 4;

  typedef enum logic [STATE_W-1:0] {
    EXIT2_DR  = 4'h0,
    EXIT1_DR  = 4'h1,
    SHIFT_DR  = 4'h2,
    PAUSE_DR  = 4'h3,
    SEL_IR    = 4'h4,
    UPDATE_DR = 4'h5,
    CAP_DR    = 4'h6,
    SEL_DR    = 4'h7,
    EXIT2_IR  = 4'h8,
    EXIT1_IR  = 4'h9,
    SHIFT_IR  = 4'hA,
    PAUSE_IR  = 4'hB,
    RTI       = 4'hC,
    UPDATE_IR = 4'hD,
    CAP_IR    = 4'hE,
    TLR       = 4'hF
  } tap_state_e;

  localparam logic [IR_SIZE-1:0] EXTEST         = 3'b000;
  localparam logic [IR_SIZE-1:0] INTEST         = 3'b001;
  localparam logic [IR_SIZE-1:0] SAMPLE_PRELOAD = 3'b010;
  localparam logic [IR_SIZE-1:0] BYPASS         = 3'b111;

endpackage

// File: rtl/tap_scan_controller_if.sv
// Pin-level bundle between the chip JTAG pins / BSR instance and the TAP
// controller.
// slave  (controller side): in  TMS, TDI, bsr_scan_out
//                           out TDO, TDO_enable, shiftDR, clockDR,
//                               updateDR, mode, tap_state
// master (pins/BSR side):   the mirror image.
interface tap_scan_controller_if;
  import tap_pkg::*;

  logic               TMS;
  logic               TDI;
  logic               bsr_scan_out;
  logic               TDO;
  logic               TDO_enable;
  logic               shiftDR;
  logic               clockDR;
  logic               updateDR;
  logic               mode;
  logic [STATE_W-1:0] tap_state;

  modport slave (
    input  TMS, TDI, bsr_scan_out,
    output TDO, TDO_enable, shiftDR, clockDR, updateDR, mode, tap_state
  );

  modport master (
    output TMS, TDI, bsr_scan_out,
    input  TDO, TDO_enable, shiftDR, clockDR, updateDR, mode, tap_state
  );

endinterface

// File: rtl/tap_instruction_register.sv
// Instruction register: rising-edge shift stage, falling-edge latch and
// opcode decode.
// Ports: TCK, reset (async, active-high), state (current TAP state),
//        TDI (serial in), ir_lsb (serial out toward TDO),
//        mode (BSR drives from update stage), select_bsr (BSR vs bypass).
module tap_instruction_register
  import tap_pkg::*;
#(
  parameter int                 IR_size    = IR_SIZE,
  parameter logic [IR_size-1:0] IR_capture = IR_size'(1)
) (
  input  logic       TCK,
  input  logic       reset,
  input  tap_state_e state,
  input  logic       TDI,
  output logic       ir_lsb,
  output logic       mode,
  output logic       select_bsr
);

  localparam logic [IR_size-1:0] OP_EXTEST = IR_size'(EXTEST);
  localparam logic [IR_size-1:0] OP_INTEST = IR_size'(INTEST);
  localparam logic [IR_size-1:0] OP_SAMPLE = IR_size'(SAMPLE_PRELOAD);
  // Sign-extend so a wider IR still parks on all ones.
  localparam logic [IR_size-1:0] OP_BYPASS = IR_size'(signed'(BYPASS));

  logic [IR_size-1:0] ir_shift;
  logic [IR_size-1:0] ir_latch;

  always_ff @(posedge TCK or posedge reset) begin
    if (reset) begin
      ir_shift <= '0;
    end else if (state == CAP_IR) begin
      ir_shift <= IR_capture;
    end else if (state == SHIFT_IR) begin
      ir_shift <= {TDI, ir_shift[IR_size-1:1]};
    end
  end

  // Latch on the falling edge so the new instruction is applied mid-state,
  // away from the edge that moves the FSM.
  always_ff @(negedge TCK or posedge reset) begin
    if (reset) begin
      ir_latch <= OP_BYPASS;
    end else if (state == TLR) begin
      ir_latch <= OP_BYPASS;
    end else if (state == UPDATE_IR) begin
      ir_latch <= ir_shift;
    end
  end

  assign ir_lsb     = ir_shift[0];
  assign mode       = (ir_latch == OP_EXTEST) || (ir_latch == OP_INTEST);
  assign select_bsr = mode || (ir_latch == OP_SAMPLE);

endmodule

// File: rtl/tap_scan_controller.sv
// TAP controller for the 8-bit boundary-scan chain: 16-state TAP FSM,
// BSR strobes, instruction register, bypass bit and TDO mux.
// Ports: TCK (test clock), reset (async, active-high),
//        jtag (slave modport: TMS/TDI/bsr_scan_out in; TDO, TDO_enable,
//        shiftDR, clockDR, updateDR, mode, tap_state out).
module tap_scan_controller
  import tap_pkg::*;
#(
  parameter int                 IR_size    = IR_SIZE,
  parameter logic [IR_size-1:0] IR_capture = IR_size'(1)
) (
  input  logic                  TCK,
  input  logic                  reset,
  tap_scan_controller_if.slave  jtag
);

  tap_state_e state;
  logic       bypass_bit;
  logic       dr_clk_en;
  logic       shift_dr_q;
  logic       update_dr_q;
  logic       tdo_q;
  logic       tdo_en_q;
  logic       ir_lsb;
  logic       ir_mode;
  logic       select_bsr;

  tap_instruction_register #(
    .IR_size    (IR_size),
    .IR_capture (IR_capture)
  ) u_ir (
    .TCK        (TCK),
    .reset      (reset),
    .state      (state),
    .TDI        (jtag.TDI),
    .ir_lsb     (ir_lsb),
    .mode       (ir_mode),
    .select_bsr (select_bsr)
  );

  always_ff @(posedge TCK or posedge reset) begin
    if (reset) begin
      state <= TLR;
    end else begin
      unique case (state)
        TLR:       state <= jtag.TMS ? TLR       : RTI;
        RTI:       state <= jtag.TMS ? SEL_DR    : RTI;
        SEL_DR:    state <= jtag.TMS ? SEL_IR    : CAP_DR;
        CAP_DR:    state <= jtag.TMS ? EXIT1_DR  : SHIFT_DR;
        SHIFT_DR:  state <= jtag.TMS ? EXIT1_DR  : SHIFT_DR;
        EXIT1_DR:  state <= jtag.TMS ? UPDATE_DR : PAUSE_DR;
        PAUSE_DR:  state <= jtag.TMS ? EXIT2_DR  : PAUSE_DR;
        EXIT2_DR:  state <= jtag.TMS ? UPDATE_DR : SHIFT_DR;
        UPDATE_DR: state <= jtag.TMS ? SEL_DR    : RTI;
        SEL_IR:    state <= jtag.TMS ? TLR       : CAP_IR;
        CAP_IR:    state <= jtag.TMS ? EXIT1_IR  : SHIFT_IR;
        SHIFT_IR:  state <= jtag.TMS ? EXIT1_IR  : SHIFT_IR;
        EXIT1_IR:  state <= jtag.TMS ? UPDATE_IR : PAUSE_IR;
        PAUSE_IR:  state <= jtag.TMS ? EXIT2_IR  : PAUSE_IR;
        EXIT2_IR:  state <= jtag.TMS ? UPDATE_IR : SHIFT_IR;
        UPDATE_IR: state <= jtag.TMS ? SEL_DR    : RTI;
        default:   state <= TLR;
      endcase
    end
  end

  always_ff @(posedge TCK or posedge reset) begin
    if (reset) begin
      bypass_bit <= 1'b0;
    end else if (state == CAP_DR) begin
      bypass_bit <= 1'b0;
    end else if (state == SHIFT_DR) begin
      bypass_bit <= jtag.TDI;
    end
  end

  // Falling-edge strobes: each settles half a period before the rising
  // edge that acts on it. dr_clk_en only changes while TCK is low, so the
  // gated clockDR below cannot glitch.
  always_ff @(negedge TCK or posedge reset) begin
    if (reset) begin
      shift_dr_q  <= 1'b0;
      update_dr_q <= 1'b0;
      dr_clk_en   <= 1'b0;
      tdo_q       <= 1'b0;
      tdo_en_q    <= 1'b0;
    end else begin
      shift_dr_q  <= (state == SHIFT_DR);
      update_dr_q <= (state == UPDATE_DR);
      dr_clk_en   <= (state == CAP_DR) || (state == SHIFT_DR);
      if (state == SHIFT_IR) begin
        tdo_q    <= ir_lsb;
        tdo_en_q <= 1'b1;
      end else if (state == SHIFT_DR) begin
        tdo_q    <= select_bsr ? jtag.bsr_scan_out : bypass_bit;
        tdo_en_q <= 1'b1;
      end else begin
        tdo_q    <= 1'b0;
        tdo_en_q <= 1'b0;
      end
    end
  end

  assign jtag.clockDR    = TCK & dr_clk_en;
  assign jtag.shiftDR    = shift_dr_q;
  assign jtag.updateDR   = update_dr_q;
  assign jtag.TDO        = tdo_q;
  assign jtag.TDO_enable = tdo_en_q;
  assign jtag.mode       = ir_mode;
  assign jtag.tap_state  = state;

endmodule

// File: tb/tb_tap_scan_controller.sv
// Bench for tap_scan_controller: an 8-bit BSR stand-in driven by the DUT
// strobes, a state-table reference model, a per-cycle compare process,
// directed scans with literal expectations and a randomized TMS/TDI phase.
module tb_tap_scan_controller;

  logic TCK   = 1'b0;
  logic reset = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  tap_scan_controller_if jt();

  tap_scan_controller dut (
    .TCK   (TCK),
    .reset (reset),
    .jtag  (jt)
  );

  always #5 TCK = ~TCK;

  localparam logic [3:0] S_TLR    = 4'hF;
  localparam logic [3:0] S_RTI    = 4'hC;
  localparam logic [3:0] S_CAP_DR = 4'h6;
  localparam logic [3:0] S_SH_DR  = 4'h2;
  localparam logic [3:0] S_UPD_DR = 4'h5;
  localparam logic [3:0] S_CAP_IR = 4'hE;
  localparam logic [3:0] S_SH_IR  = 4'hA;
  localparam logic [3:0] S_UPD_IR = 4'hD;

  // Next state by current code, for TMS = 0 and TMS = 1.
  logic [3:0] nxt0 [16] = '{4'h2, 4'h3, 4'h2, 4'h3, 4'hE, 4'hC, 4'h2, 4'h6,
                            4'hA, 4'hB, 4'hA, 4'hB, 4'hC, 4'hC, 4'hA, 4'hC};
  logic [3:0] nxt1 [16] = '{4'h5, 4'h5, 4'h1, 4'h0, 4'hF, 4'h7, 4'h1, 4'h4,
                            4'hD, 4'hD, 4'h9, 4'h8, 4'h7, 4'h7, 4'h9, 4'hF};

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- BSR stand-in ----------------
  logic [7:0] bsr_sr  = 8'h00;
  logic [7:0] bsr_upd = 8'h00;
  logic [7:0] bsr_pin = 8'h00;
  int n_cap   = 0;
  int n_shift = 0;
  int n_upd   = 0;

  assign jt.bsr_scan_out = bsr_sr[0];

  always @(posedge jt.clockDR) begin
    if (jt.shiftDR) begin
      bsr_sr <= {jt.TDI, bsr_sr[7:1]};
      n_shift++;
    end else begin
      bsr_sr <= bsr_pin;
      n_cap++;
    end
  end

  always @(posedge jt.updateDR) begin
    bsr_upd <= bsr_sr;
    n_upd++;
  end

  // ---------------- reference model ----------------
  logic [3:0] m_state = S_TLR;
  logic [2:0] m_ir    = 3'b000;
  logic [2:0] m_latch = 3'b111;
  logic       m_byp   = 1'b0;
  logic e_shift = 1'b0, e_upd = 1'b0, e_en = 1'b0, e_tdo = 1'b0, e_tdoen = 1'b0;

  function automatic logic uses_bsr(input logic [2:0] ir);
    return (ir == 3'b000) || (ir == 3'b001) || (ir == 3'b010);
  endfunction

  function automatic logic ext_mode(input logic [2:0] ir);
    return (ir == 3'b000) || (ir == 3'b001);
  endfunction

  always @(posedge TCK or posedge reset) begin
    if (reset) begin
      m_state = S_TLR;
      m_ir    = 3'b000;
      m_byp   = 1'b0;
    end else begin
      if (m_state == S_CAP_IR) m_ir = 3'b001;
      if (m_state == S_SH_IR)  m_ir = {jt.TDI, m_ir[2:1]};
      if (m_state == S_CAP_DR) m_byp = 1'b0;
      if (m_state == S_SH_DR)  m_byp = jt.TDI;
      m_state = jt.TMS ? nxt1[m_state] : nxt0[m_state];
    end
  end

  always @(negedge TCK or posedge reset) begin
    if (reset) begin
      {e_shift, e_upd, e_en, e_tdo, e_tdoen} = 5'b0;
      m_latch = 3'b111;
    end else begin
      e_shift = (m_state == S_SH_DR);
      e_upd   = (m_state == S_UPD_DR);
      e_en    = (m_state == S_CAP_DR) || (m_state == S_SH_DR);
      e_tdoen = (m_state == S_SH_DR) || (m_state == S_SH_IR);
      if (m_state == S_SH_IR)      e_tdo = m_ir[0];
      else if (m_state == S_SH_DR) e_tdo = uses_bsr(m_latch) ? jt.bsr_scan_out : m_byp;
      else                         e_tdo = 1'b0;
      if (m_state == S_TLR)         m_latch = 3'b111;
      else if (m_state == S_UPD_IR) m_latch = m_ir;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge TCK) begin
    #2;
    chk("tap_state",  8'(jt.tap_state),  8'(m_state));
    chk("shiftDR",    8'(jt.shiftDR),    8'(e_shift));
    chk("updateDR",   8'(jt.updateDR),   8'(e_upd));
    chk("TDO",        8'(jt.TDO),        8'(e_tdo));
    chk("TDO_enable", 8'(jt.TDO_enable), 8'(e_tdoen));
    chk("mode",       8'(jt.mode),       8'(ext_mode(m_latch)));
    chk("clockDR_lo", 8'(jt.clockDR),    8'd0);
  end

  always @(posedge TCK) begin
    #2;
    chk("clockDR_hi", 8'(jt.clockDR), 8'(e_en));
  end

  // ---------------- stimulus ----------------
  // TDO bits seen in shift states; newest bit enters at obs[0].
  logic [15:0] obs  = 16'h0;
  int          nobs = 0;

  task automatic clr();
    obs = 16'h0; nobs = 0;
    n_cap = 0; n_shift = 0; n_upd = 0;
  endtask

  task automatic step(input logic tms, input logic tdi);
    jt.TMS = tms;
    jt.TDI = tdi;
    @(posedge TCK);
    @(negedge TCK);
    #3;
    if (jt.TDO_enable) begin
      obs = {obs[14:0], jt.TDO};
      nobs++;
    end
  endtask

  task automatic load_ir(input logic [2:0] code);
    step(1'b1, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(i == 2, code[i]);
    step(1'b1, 1'b0); step(1'b0, 1'b0);
  endtask

  task automatic dr_scan(input logic [7:0] bits, input int n);
    step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
    for (int i = 0; i < n; i++) step(i == n - 1, bits[i]);
    step(1'b1, 1'b0); step(1'b0, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int snap;
    logic [7:0] pat;
    jt.TMS = 1'b1;
    jt.TDI = 1'b0;
    #1 reset = 1'b1;
    #2;
    chk("rst_state",    8'(jt.tap_state),  8'h0F);
    chk("rst_TDO",      8'(jt.TDO),        8'd0);
    chk("rst_TDO_en",   8'(jt.TDO_enable), 8'd0);
    chk("rst_shiftDR",  8'(jt.shiftDR),    8'd0);
    chk("rst_clockDR",  8'(jt.clockDR),    8'd0);
    chk("rst_updateDR", 8'(jt.updateDR),   8'd0);
    chk("rst_mode",     8'(jt.mode),       8'd0);
    @(negedge TCK); #3;
    reset = 1'b0;
    step(1'b0, 1'b0);

    // IR scan loading EXTEST; captured 001 must come out LSB first.
    clr();
    step(1'b1, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
    step(1'b0, 1'b0); step(1'b0, 1'b0); step(1'b1, 1'b0);
    chk("ir_tdo_bits",  8'(obs[2:0]), 8'b100);
    chk("ir_tdo_count", 8'(nobs),     8'd3);
    chk("mode_pre_upd", 8'(jt.mode),  8'd0);
    step(1'b1, 1'b0);
    chk("upd_ir_state", 8'(jt.tap_state), 8'(S_UPD_IR));
    chk("mode_extest",  8'(jt.mode),      8'd1);
    step(1'b0, 1'b0);

    // Five TMS=1 edges from inside Shift_DR reach TLR and drop to BYPASS.
    step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b1);
    chk("mid_shdr_mode", 8'(jt.mode), 8'd1);
    repeat (5) step(1'b1, 1'b0);
    chk("tlr_state",  8'(jt.tap_state),  8'h0F);
    chk("tlr_mode",   8'(jt.mode),       8'd0);
    chk("tlr_TDO_en", 8'(jt.TDO_enable), 8'd0);
    step(1'b0, 1'b0);

    // BYPASS: captured 0 then TDI 1,0,1 one TCK late; BSR output ignored.
    clr();
    bsr_pin = 8'h3C;
    dr_scan(8'b0000_1101, 4);
    chk("byp_tdo_bits",  8'(obs[3:0]), 8'b0101);
    chk("byp_tdo_count", 8'(nobs),     8'd4);
    chk("byp_cap_clk",   8'(n_cap),    8'd1);
    chk("byp_shift_clk", 8'(n_shift),  8'd4);

    // SAMPLE_PRELOAD: BSR captures AA and shifts out 0,1,0,1,...
    load_ir(3'b010);
    chk("sp_mode", 8'(jt.mode), 8'd0);
    clr();
    bsr_pin = 8'hAA;
    dr_scan(8'hFF, 8);
    chk("sp_tdo_bits",  obs[7:0],     8'h55);
    chk("sp_cap_clk",   8'(n_cap),    8'd1);
    chk("sp_shift_clk", 8'(n_shift),  8'd8);
    chk("sp_upd_count", 8'(n_upd),    8'd1);
    chk("sp_bsr_upd",   bsr_upd,      8'hFF);
    chk("sp_mode_end",  8'(jt.mode),  8'd0);

    // Pause_DR for three cycles after three bits, then resume.
    clr();
    pat = 8'h5C;
    step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(i == 2, pat[i]);
    snap = n_shift;
    step(1'b0, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
    step(1'b1, 1'b0); step(1'b0, 1'b0);
    chk("pause_pre_clk",  8'(snap),    8'd3);
    chk("pause_no_clk",   8'(n_shift), 8'(snap));
    for (int i = 3; i < 8; i++) step(i == 7, pat[i]);
    step(1'b1, 1'b0); step(1'b0, 1'b0);
    chk("pause_tdo_bits", obs[7:0],    8'h55);
    chk("pause_tdo_cnt",  8'(nobs),    8'd8);
    chk("pause_shift",    8'(n_shift), 8'd8);
    chk("pause_bsr_upd",  bsr_upd,     8'h5C);

    // Async reset between edges while in Shift_IR.
    load_ir(3'b000);
    chk("pre_rst_mode", 8'(jt.mode), 8'd1);
    step(1'b1, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b1);
    chk("pre_rst_TDO_en", 8'(jt.TDO_enable), 8'd1);
    @(posedge TCK); #3;
    reset = 1'b1;
    #1;
    chk("arst_state",    8'(jt.tap_state),  8'h0F);
    chk("arst_TDO",      8'(jt.TDO),        8'd0);
    chk("arst_TDO_en",   8'(jt.TDO_enable), 8'd0);
    chk("arst_mode",     8'(jt.mode),       8'd0);
    chk("arst_shiftDR",  8'(jt.shiftDR),    8'd0);
    chk("arst_clockDR",  8'(jt.clockDR),    8'd0);
    chk("arst_updateDR", 8'(jt.updateDR),   8'd0);
    @(negedge TCK); #3;
    reset = 1'b0;
    step(1'b0, 1'b0);

    // Randomized TMS/TDI with occasional async reset pulses.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        reset = 1'b1;
        #1;
        reset = 1'b0;
      end
      if ($urandom_range(0, 7) == 0) bsr_pin = 8'($urandom);
      step($urandom_range(0, 9) < 3, 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
